// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM front-end state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// Maps HSIZE and the low byte-address bits to SRAM byte write enables.
module ahb_byte_strobe_gen
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] we,
  output logic       illegal
);

  always_comb begin
    we      = '0;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: we = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            we = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  we = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave driving a single-port SRAM: zero-wait reads and writes,
// one stall on read-after-write port collision, two-cycle ERROR on bad transfers.
module ahb_sram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          HSEL,
  input  logic [AW+1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [DW-1:0] HWDATA,
  output logic [DW-1:0] HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          ME,
  output logic [3:0]    WE,
  output logic [AW-1:0] ADR,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  logic [1:0]    rst_sync;
  logic          rst_n_int;
  state_t        state, state_nxt;
  logic [AW-1:0] wr_adr, rd_adr;
  logic [3:0]    wr_we;
  logic [3:0]    strb;
  logic          illegal;
  logic          can_accept, accept, acc_rd, acc_wr, collide;

  ahb_byte_strobe_gen u_strobe (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .we      (strb),
    .illegal (illegal)
  );

  // Reset asserts immediately, releases two clocks after reset_n rises.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign can_accept = (state == ST_IDLE) || (state == ST_RD_DATA) ||
                      (state == ST_WR_DATA) || (state == ST_ERR2);
  assign accept  = rst_n_int && can_accept && HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign acc_rd  = accept && !illegal && !HWRITE;
  assign acc_wr  = accept && !illegal && HWRITE;
  // A read address phase cannot use the SRAM while a write data phase owns it.
  assign collide = acc_rd && (state == ST_WR_DATA);

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state  <= ST_IDLE;
      wr_adr <= '0;
      wr_we  <= '0;
      rd_adr <= '0;
    end else begin
      state <= state_nxt;
      if (acc_wr) begin
        wr_adr <= HADDR[AW+1:2];
        wr_we  <= strb;
      end
      if (collide) rd_adr <= HADDR[AW+1:2];
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RD_STALL: state_nxt = ST_RD_DATA;
      ST_ERR1:     state_nxt = ST_ERR2;
      default: begin
        if (accept) begin
          if (illegal)     state_nxt = ST_ERR1;
          else if (HWRITE) state_nxt = ST_WR_DATA;
          else if (collide) state_nxt = ST_RD_STALL;
          else             state_nxt = ST_RD_DATA;
        end
      end
    endcase
  end

  always_comb begin
    ME  = 1'b0;
    WE  = '0;
    ADR = '0;
    D   = '0;
    case (state)
      ST_WR_DATA: begin
        ME  = 1'b1;
        WE  = wr_we;
        ADR = wr_adr;
        D   = HWDATA;
      end
      ST_RD_STALL: begin
        ME  = 1'b1;
        ADR = rd_adr;
      end
      default: begin
        if (acc_rd) begin
          ME  = 1'b1;
          ADR = HADDR[AW+1:2];
        end
      end
    endcase
  end

  assign HREADYOUT = !((state == ST_RD_STALL) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (state == ST_RD_DATA) ? Q : '0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural 2kx32 SRAM model.
module tb_ahb_sram_ctrl;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          CLK;
  logic          reset_n;
  logic          HSEL;
  logic [AW+1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic          ME;
  logic [3:0]    WE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  int total  = 0;
  int passed = 0;

  logic [31:0] mem [0:2047];

  // Single slave on the bus: global HREADY follows this slave.
  assign HREADY = HREADYOUT;

  ahb_sram_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .reset_n(reset_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .ME(ME), .WE(WE),
    .ADR(ADR), .D(D), .Q(Q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SRAM model: synchronous, read data valid the cycle after ME.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[1] = 32'hCAFEF00D;
    mem[2] = 32'h0BADC0DE;
    Q = '0;
    forever begin
      @(posedge CLK);
      if (ME) begin
        Q <= mem[ADR];
        for (int b = 0; b < 4; b++)
          if (WE[b]) mem[ADR][8*b +: 8] = D[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] size, input logic [AW+1:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HADDR = a;
  endtask

  initial begin
    reset_n = 1'b0;
    HWDATA  = '0;
    bus_idle();
    #3;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(HRESP),     32'd0);
    chk("rst_me",        32'(ME),        32'd0);
    chk("rst_we",        32'(WE),        32'd0);
    chk("rst_adr",       32'(ADR),       32'd0);
    chk("rst_d",         D,              32'd0);
    chk("rst_hrdata",    HRDATA,         32'd0);
    step();
    reset_n = 1'b1;
    repeat (3) step();

    // word write 0xDEADBEEF @0x010, then colliding read @0x010
    addr_phase(1'b1, 3'd2, 13'h010);
    #3 chk("wr_addr_me", 32'(ME), 32'd0);
    step();
    HWDATA = 32'hDEADBEEF;
    addr_phase(1'b0, 3'd2, 13'h010);
    #3;
    chk("wr_me",        32'(ME),        32'd1);
    chk("wr_we",        32'(WE),        32'hF);
    chk("wr_adr",       32'(ADR),       32'd4);
    chk("wr_d",         D,              32'hDEADBEEF);
    chk("wr_hreadyout", 32'(HREADYOUT), 32'd1);
    step();
    HWDATA = '0;
    bus_idle();
    #3;
    chk("stall_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("stall_me",        32'(ME),        32'd1);
    chk("stall_we",        32'(WE),        32'd0);
    chk("stall_adr",       32'(ADR),       32'd4);
    step();
    #3;
    chk("col_rd_hrdata",    HRDATA,         32'hDEADBEEF);
    chk("col_rd_hreadyout", 32'(HREADYOUT), 32'd1);
    step();

    // byte write 0xAA @0x013, then non-colliding read @0x010
    addr_phase(1'b1, 3'd0, 13'h013);
    step();
    HWDATA = 32'hAA000000;
    bus_idle();
    #3;
    chk("byte_we",  32'(WE),  32'h8);
    chk("byte_d",   D,        32'hAA000000);
    chk("byte_adr", 32'(ADR), 32'd4);
    step();
    HWDATA = '0;
    addr_phase(1'b0, 3'd2, 13'h010);
    #3;
    chk("rd_addr_me",  32'(ME),  32'd1);
    chk("rd_addr_we",  32'(WE),  32'd0);
    chk("rd_addr_adr", 32'(ADR), 32'd4);
    step();
    addr_phase(1'b1, 3'd1, 13'h002);
    #3;
    chk("rd_hrdata",    HRDATA,         32'hAAADBEEF);
    chk("rd_hreadyout", 32'(HREADYOUT), 32'd1);
    step();

    // half write @0x002 data phase, then illegal half @0x001
    HWDATA = 32'h12345678;
    addr_phase(1'b1, 3'd1, 13'h001);
    #3;
    chk("half_we",  32'(WE),  32'hC);
    chk("half_adr", 32'(ADR), 32'd0);
    step();
    HWDATA = 32'hFFFFFFFF;
    bus_idle();
    #3;
    chk("err1_hresp", 32'(HRESP),     32'd1);
    chk("err1_rdy",   32'(HREADYOUT), 32'd0);
    chk("err1_me",    32'(ME),        32'd0);
    step();
    #3;
    chk("err2_hresp", 32'(HRESP),     32'd1);
    chk("err2_rdy",   32'(HREADYOUT), 32'd1);
    chk("err2_me",    32'(ME),        32'd0);
    step();
    HWDATA = '0;
    #3 chk("post_err_hresp", 32'(HRESP), 32'd0);

    // back-to-back reads @0x000, 0x004, 0x008
    addr_phase(1'b0, 3'd2, 13'h000);
    #3 chk("b2b_adr0", 32'(ADR), 32'd0);
    step();
    addr_phase(1'b0, 3'd2, 13'h004);
    #3;
    chk("b2b_data0", HRDATA,         32'h12340000);
    chk("b2b_rdy0",  32'(HREADYOUT), 32'd1);
    chk("b2b_adr1",  32'(ADR),       32'd1);
    step();
    addr_phase(1'b0, 3'd2, 13'h008);
    #3;
    chk("b2b_data1", HRDATA,         32'hCAFEF00D);
    chk("b2b_rdy1",  32'(HREADYOUT), 32'd1);
    chk("b2b_adr2",  32'(ADR),       32'd2);
    step();
    bus_idle();
    #3;
    chk("b2b_data2", HRDATA,         32'hBADC0DE);
    chk("b2b_rdy2",  32'(HREADYOUT), 32'd1);
    step();

    // reset during a write data phase drops the write
    addr_phase(1'b1, 3'd2, 13'h004);
    step();
    HWDATA = 32'h55555555;
    bus_idle();
    #3 chk("mid_wr_me", 32'(ME), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_me",     32'(ME),        32'd0);
    chk("mid_rst_we",     32'(WE),        32'd0);
    chk("mid_rst_adr",    32'(ADR),       32'd0);
    chk("mid_rst_d",      D,              32'd0);
    chk("mid_rst_rdy",    32'(HREADYOUT), 32'd1);
    chk("mid_rst_hresp",  32'(HRESP),     32'd0);
    step();
    HWDATA  = '0;
    reset_n = 1'b1;
    repeat (3) step();
    addr_phase(1'b0, 3'd2, 13'h004);
    step();
    bus_idle();
    #3 chk("post_rst_read", HRDATA, 32'hCAFEF00D);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave front-end that drives the 2kx32 single-port SRAM wrapper (ME, WE[3:0], ADR, D; returns Q).
- Sits directly upstream of the SRAM wrapper on the low-power subsystem bus.
- Converts AHB address/data-phase pipelining into SRAM cycles, generates byte write enables, and returns read data.
- Inserts one wait state on a read-after-write port collision and errors illegal transfers.

Parameters:
- AW, 11: SRAM word address width. Byte address is AW+2 bits.
- DW, 32: data width. Only 32 is supported; byte lanes are fixed at 4.

Ports:
- CLK  in  1  clock
- reset_n  in  1  async active-low reset
- HSEL  in  1  slave select
- HADDR  in  AW+2  byte address
- HTRANS  in  2  transfer type; NONSEQ/SEQ are active
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word
- HREADY  in  1  bus ready (global)
- HWDATA  in  DW  write data (data phase)
- HRDATA  out  DW  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- ME  out  1  SRAM enable
- WE  out  4  SRAM byte write enables
- ADR  out  AW  SRAM word address
- D  out  DW  SRAM write data
- Q  in  DW  SRAM read data (valid 1 cycle after ME)

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, ME=0, WE=0, ADR=0, D=0, HRDATA=0, state=IDLE. Asynchronous assertion, synchronous release.
- Transfer accepted when HSEL & HTRANS[1] & HREADY.
- Byte strobes, in address phase:
  - byte: WE bit HADDR[1:0].
  - half: HADDR[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Illegal transfer: HSIZE>2, half with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - No SRAM access.
  - Two-cycle ERROR: cycle 1 HRESP=1/HREADYOUT=0, cycle 2 HRESP=1/HREADYOUT=1.
- Read, no collision:
  - Address phase drives ME=1, WE=0, ADR=HADDR[AW+1:2] combinationally.
  - Data phase: HRDATA=Q, HREADYOUT=1. Zero wait states.
- Write:
  - Address, strobes and valid flag registered in the address phase.
  - Data phase drives ME=1, WE=stored strobes, ADR=stored address, D=HWDATA, HREADYOUT=1. Zero wait states.
- Collision: a read address phase in the same cycle as a write data phase (SRAM port busy).
  - Read address is captured.
  - t+1: ME=1 for the read, HREADYOUT=0.
  - t+2: HRDATA=Q, HREADYOUT=1.
  - A write followed by a write never collides.
- Read of a just-written address after a stall returns the new data; the SRAM write completes before the read.
- States:
  - IDLE: no data phase pending.
  - WR_DATA: write data phase.
  - RD_DATA: read data phase.
  - RD_STALL: deferred read issued, HREADYOUT=0.
  - ERR1, ERR2: the two ERROR cycles.
- Transitions: next state is taken from the accepted transfer in the current cycle. IDLE/RD_DATA/WR_DATA each accept a new transfer. RD_STALL always goes to RD_DATA. ERR1 always goes to ERR2.
- HTRANS IDLE/BUSY, or HSEL=0: no SRAM access, OKAY, state → IDLE after the current data phase.
- ADR/D/WE are don't-care when ME=0, but are driven to 0 (holds toggle power low).
- Reset mid-write: the pending write is dropped and the SRAM is not written.

Decomposition:
- Shared package ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP values, state enum.
- One sub-module: ahb_byte_strobe_gen. Combinational HSIZE+HADDR[1:0] → WE[3:0] plus an illegal flag.

Test Plan:
- Word write 0xDEADBEEF @0x010, then word read @0x010 → write is zero-wait, WE=1111 with ADR=4; read returns 0xDEADBEEF with one stall cycle (collision).
- Byte write 0xAA to 0x013 after an idle cycle, then read @0x010 → WE=1000, D[31:24]=0xAA; read returns 0xAAADBEEF with no stall.
- Half write @0x002 → WE=1100.
- Half write @0x001 → ERROR pair, ME stays 0, memory unchanged.
- Back-to-back reads @0x000, 0x004, 0x008 → each zero-wait, HRDATA correct each data phase.
- Assert reset_n low during a write data phase → outputs at reset values immediately; a subsequent read shows the old data.
